// File: rtl/bsg_link_rx_pkg.sv
// Shared definitions for the receive side of a DDR link channel.
//   - Default channel geometry (half-word width, buffer depth, token decimation).
//   - count_width(): width of an occupancy counter able to hold 0..depth.
//   - stage_s: input stage register layout (valid bit plus reassembled word)
//     at the default channel width.
package bsg_link_rx_pkg;

  localparam int CHANNEL_WIDTH_DEF    = 8;
  localparam int FIFO_DEPTH_DEF       = 64;
  localparam int TOKEN_DECIMATION_DEF = 8;

  // An occupancy counter must represent both 0 and depth, hence one extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic                           v;
    logic [2*CHANNEL_WIDTH_DEF-1:0] d;
  } stage_s;

endpackage

// File: rtl/bsg_link_rx_fifo.sv
// Single-clock circular FIFO used to buffer received link words.
// A write is accepted when the FIFO is not full, or when it is full and the
// head is dequeued in the same cycle.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   w_v        write request
//   w_data     word to write
//   full       count == DEPTH
//   r_yumi     dequeue head (ignored when r_v = 0)
//   r_v        head is valid (count != 0)
//   r_data     head word, zero when empty
//   count      words currently buffered
module bsg_link_rx_fifo
  import bsg_link_rx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_v,
  input  logic [WIDTH-1:0]              w_data,
  output logic                          full,
  input  logic                          r_yumi,
  output logic                          r_v,
  output logic [WIDTH-1:0]              r_data,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] cnt;
  logic             rd;
  logic             wr;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign r_v    = (cnt != '0);
  assign rd     = r_yumi & r_v;
  // When full, the slot being written is the head slot; the head has already
  // been presented on r_data this cycle, so overwriting it at the edge is safe.
  assign wr     = w_v & (~full | rd);
  assign r_data = r_v ? mem[rptr] : '0;
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= w_data;
  end

  // Pointers are exactly log2(DEPTH) bits and wrap without explicit compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (wr && !rd)      cnt <= cnt + 1'b1;
      else if (rd && !wr) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bsg_link_ddr_downstream_ch.sv
// Receive side of one DDR link channel.
// Reassembles the pos/neg half-words captured by the IDDR into full words,
// buffers them in a credit-sized FIFO, presents them to the core with a
// valid/yumi handshake, and returns credits by toggling a token line once per
// TOKEN_DECIMATION dequeues.
// Ports:
//   clk, rst        io-domain clock; synchronous active-high reset
//   io_valid_pos_i  valid of half captured on rising io edge
//   io_valid_neg_i  valid of half captured on falling io edge
//   io_data_pos_i   low half-word
//   io_data_neg_i   high half-word
//   core_valid_o    FIFO head valid
//   core_data_o     FIFO head word {neg,pos}
//   core_yumi_i     dequeue head this cycle
//   io_token_r_o    registered credit token line
//   fifo_count_o    words currently buffered
//   err_overflow_o  sticky: word arrived with FIFO full and no dequeue
//   err_half_o      sticky: only one half of a word was valid
module bsg_link_ddr_downstream_ch
  import bsg_link_rx_pkg::*;
#(
  parameter int CHANNEL_WIDTH    = CHANNEL_WIDTH_DEF,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF,
  parameter int TOKEN_DECIMATION = TOKEN_DECIMATION_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               io_valid_pos_i,
  input  logic                               io_valid_neg_i,
  input  logic [CHANNEL_WIDTH-1:0]           io_data_pos_i,
  input  logic [CHANNEL_WIDTH-1:0]           io_data_neg_i,
  output logic                               core_valid_o,
  output logic [2*CHANNEL_WIDTH-1:0]         core_data_o,
  input  logic                               core_yumi_i,
  output logic                               io_token_r_o,
  output logic [count_width(FIFO_DEPTH)-1:0] fifo_count_o,
  output logic                               err_overflow_o,
  output logic                               err_half_o
);

  // A decimation of 1 still needs a one-bit counter to keep widths legal.
  localparam int DEQ_W = (TOKEN_DECIMATION > 1) ? $clog2(TOKEN_DECIMATION) : 1;

  // Same layout as stage_s, but sized by this instance's channel width.
  typedef struct packed {
    logic                       v;
    logic [2*CHANNEL_WIDTH-1:0] d;
  } stage_t;

  stage_t           stage;
  logic             full;
  logic             deq;
  logic [DEQ_W-1:0] deq_cnt;

  assign deq = core_yumi_i & core_valid_o;

  bsg_link_rx_fifo #(
    .WIDTH (2*CHANNEL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clk    (clk),
    .rst    (rst),
    .w_v    (stage.v),
    .w_data (stage.d),
    .full   (full),
    .r_yumi (core_yumi_i),
    .r_v    (core_valid_o),
    .r_data (core_data_o),
    .count  (fifo_count_o)
  );

  // A lone half is unrecoverable: it is flagged and the stage goes invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage      <= '0;
      err_half_o <= 1'b0;
    end else begin
      stage.v <= io_valid_pos_i & io_valid_neg_i;
      stage.d <= {io_data_neg_i, io_data_pos_i};
      if (io_valid_pos_i ^ io_valid_neg_i) err_half_o <= 1'b1;
    end
  end

  // A dropped word means the upstream spent a credit it did not have.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow_o <= 1'b0;
    end else if (stage.v && full && !deq) begin
      err_overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deq_cnt      <= '0;
      io_token_r_o <= 1'b0;
    end else if (deq) begin
      if (deq_cnt == DEQ_W'(TOKEN_DECIMATION-1)) begin
        deq_cnt      <= '0;
        io_token_r_o <= ~io_token_r_o;
      end else begin
        deq_cnt <= deq_cnt + 1'b1;
      end
    end
  end

endmodule
